ifetch_stage: RTL and testbench

IFETCH_STAGE -- requirements
Module: ifetch_stage

---
 rtl/ifetch_stage.sv | 164 ++++++++++++++++
 tb/tb_ifetch_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: one-outstanding-request IMEM front end feeding the IF/ID register.
// Define FETCH_SKID_BUF_EN to add a one-entry {pc,instr} skid buffer behind IF/ID.
module ifetch_stage #(
  parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        pc_en,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  output logic        imem_rsp_ready,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;

  logic req_hs, rsp_hs, take_rsp, ifid_free, wait_done, wait_outstanding;

  // Redirect targets are word aligned, so the low address bits are ignored.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

`ifdef FETCH_SKID_BUF_EN
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
`endif

  assign imem_req_addr = pc;
  assign ifid_valid    = ifid_valid_q;
  assign ifid_pc       = ifid_pc_q;
  assign ifid_instr    = ifid_instr_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    imem_req_valid   = (state_q == REQ);
    req_hs           = imem_req_valid && imem_req_ready;
    pc_en            = reset && (redirect || req_hs);
    next_pc          = redirect ? {redirect_pc[31:2], 2'b00} : pc + 32'd4;
    ifid_free        = !ifid_valid_q || !stall;
    imem_rsp_ready   = 1'b0;
    wait_outstanding = 1'b1;
`ifdef FETCH_SKID_BUF_EN
    // A full skid means the outstanding request has already completed.
    wait_outstanding = !skid_valid_q;
`endif
    case (state_q)
`ifdef FETCH_SKID_BUF_EN
      WAIT:    imem_rsp_ready = !skid_valid_q;
`else
      WAIT:    imem_rsp_ready = !(ifid_valid_q && stall);
`endif
      DROP:    imem_rsp_ready = 1'b1;
      default: imem_rsp_ready = 1'b0;
    endcase
    rsp_hs   = imem_rsp_valid && imem_rsp_ready;
    take_rsp = (state_q == WAIT) && rsp_hs && !redirect;

    req_pc_d     = req_hs ? pc : req_pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    wait_done    = 1'b0;

`ifdef FETCH_SKID_BUF_EN
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if (redirect) begin
      ifid_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (take_rsp && ifid_free) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = req_pc_q;
      ifid_instr_d = imem_rsp_data;
      wait_done    = 1'b1;
    end else if (take_rsp) begin
      skid_valid_d = 1'b1;
      skid_pc_d    = req_pc_q;
      skid_instr_d = imem_rsp_data;
    end else if (skid_valid_q && ifid_free) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = skid_pc_q;
      ifid_instr_d = skid_instr_q;
      skid_valid_d = 1'b0;
      wait_done    = 1'b1;
    end else if (ifid_valid_q && !stall) begin
      ifid_valid_d = 1'b0;
    end
`else
    if (redirect) begin
      ifid_valid_d = 1'b0;
    end else if (take_rsp) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = req_pc_q;
      ifid_instr_d = imem_rsp_data;
      wait_done    = 1'b1;
    end else if (ifid_valid_q && !stall) begin
      ifid_valid_d = 1'b0;
    end
`endif

    state_d = state_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (req_hs) state_d = redirect ? DROP : WAIT;
      end
      WAIT: begin
        // A response landing on the redirect edge is discarded here, leaving nothing to drop.
        if (redirect)       state_d = (rsp_hs || !wait_outstanding) ? REQ : DROP;
        else if (wait_done) state_d = REQ;
      end
      DROP: begin
        if (rsp_hs) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      req_pc_q     <= 32'd0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'd0;
      ifid_instr_q <= RESET_INSTR;
`ifdef FETCH_SKID_BUF_EN
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'd0;
      skid_instr_q <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      req_pc_q     <= req_pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
`ifdef FETCH_SKID_BUF_EN
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
`endif
    end
  end

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage; the bench plays the PC register and instruction memory.
module tb_ifetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        pc_en;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;

  int checks = 0;
  int errors = 0;

  ifetch_stage dut (
    .clock          (clock),
    .reset          (reset),
    .pc             (pc),
    .next_pc        (next_pc),
    .pc_en          (pc_en),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_ready (imem_rsp_ready),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_instr     (ifid_instr)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b0;
    pc             = 32'd0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    stall          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 32'd0;

    // Reset state
    tick();
    tick();
    check("rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_ifid_pc", ifid_pc, 32'd0);
    check("rst_ifid_instr", ifid_instr, 32'h00000013);
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_rsp_ready", {31'd0, imem_rsp_ready}, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h00000040;
    #1;
    check("rst_redirect_pc_en", {31'd0, pc_en}, 32'd0);
    redirect = 1'b0;

    // First fetch at pc=0
    reset          = 1'b1;
    pc             = 32'd0;
    imem_req_ready = 1'b1;
    #1;
    check("idle_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("idle_pc_en", {31'd0, pc_en}, 32'd0);
    tick();
    check("req0_valid", {31'd0, imem_req_valid}, 32'd1);
    check("req0_addr", imem_req_addr, 32'd0);
    check("req0_pc_en", {31'd0, pc_en}, 32'd1);
    check("req0_next_pc", next_pc, 32'd4);
    tick();
    pc             = 32'd4;
    imem_req_ready = 1'b0;
    #1;
    check("wait0_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("wait0_pc_en", {31'd0, pc_en}, 32'd0);
    check("wait0_rsp_ready", {31'd0, imem_rsp_ready}, 32'd1);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h00500093;
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    check("ifid0_valid", {31'd0, ifid_valid}, 32'd1);
    check("ifid0_pc", ifid_pc, 32'd0);
    check("ifid0_instr", ifid_instr, 32'h00500093);
    check("req1_no_hs_pc_en", {31'd0, pc_en}, 32'd0);
    tick();
    check("consume_clears_valid", {31'd0, ifid_valid}, 32'd0);

    // Wrap at the top of the address space
    pc             = 32'hFFFFFFFC;
    imem_req_ready = 1'b1;
    #1;
    check("wrap_addr", imem_req_addr, 32'hFFFFFFFC);
    check("wrap_pc_en", {31'd0, pc_en}, 32'd1);
    check("wrap_next_pc", next_pc, 32'd0);
    tick();
    pc             = 32'd0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000A0B3;
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    check("wrap_ifid_pc", ifid_pc, 32'hFFFFFFFC);
    check("wrap_ifid_instr", ifid_instr, 32'h0000A0B3);

    // Stall holds IF/ID for three edges while the next fetch is in flight
    stall          = 1'b1;
    imem_req_ready = 1'b1;
    #1;
    check("stall_req_next_pc", next_pc, 32'd4);
    tick();
    check("stall1_valid", {31'd0, ifid_valid}, 32'd1);
    check("stall1_pc", ifid_pc, 32'hFFFFFFFC);
    pc             = 32'd4;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h11111111;
    #1;
`ifdef FETCH_SKID_BUF_EN
    check("stall_rsp_ready", {31'd0, imem_rsp_ready}, 32'd1);
`else
    check("stall_rsp_ready", {31'd0, imem_rsp_ready}, 32'd0);
`endif
    tick();
`ifdef FETCH_SKID_BUF_EN
    imem_rsp_valid = 1'b0;
    #1;
    check("skid_full_rsp_ready", {31'd0, imem_rsp_ready}, 32'd0);
`endif
    check("stall2_valid", {31'd0, ifid_valid}, 32'd1);
    check("stall2_instr", ifid_instr, 32'h0000A0B3);
    tick();
    check("stall3_valid", {31'd0, ifid_valid}, 32'd1);
    check("stall3_pc", ifid_pc, 32'hFFFFFFFC);
    check("stall3_instr", ifid_instr, 32'h0000A0B3);
    stall = 1'b0;
    #1;
`ifndef FETCH_SKID_BUF_EN
    check("unstall_rsp_ready", {31'd0, imem_rsp_ready}, 32'd1);
`endif
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    check("unstall_valid", {31'd0, ifid_valid}, 32'd1);
    check("unstall_pc", ifid_pc, 32'd0);
    check("unstall_instr", ifid_instr, 32'h11111111);

    // Redirect in WAIT with IF/ID held
    stall          = 1'b1;
    imem_req_ready = 1'b1;
    #1;
    check("pre_redir_next_pc", next_pc, 32'd8);
    tick();
    pc             = 32'd8;
    imem_req_ready = 1'b0;
    redirect       = 1'b1;
    redirect_pc    = 32'h00000103;
    #1;
    check("redir_pc_en", {31'd0, pc_en}, 32'd1);
    check("redir_next_pc", next_pc, 32'h00000100);
    tick();
    redirect = 1'b0;
    stall    = 1'b0;
    pc       = 32'h00000100;
    #1;
    check("redir_clears_valid", {31'd0, ifid_valid}, 32'd0);
    check("drop_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("drop_rsp_ready", {31'd0, imem_rsp_ready}, 32'd1);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEADBEEF;
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    check("drop_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    check("drop_ifid_instr", ifid_instr, 32'h11111111);
    check("post_drop_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("post_drop_req_addr", imem_req_addr, 32'h00000100);
    imem_req_ready = 1'b1;
    #1;
    check("post_drop_next_pc", next_pc, 32'h00000104);

    // Reset asserted in WAIT abandons the request
    tick();
    pc             = 32'h00000104;
    imem_req_ready = 1'b0;
    reset          = 1'b0;
    #1;
    check("midrst_rsp_ready", {31'd0, imem_rsp_ready}, 32'd0);
    check("midrst_ifid_instr", ifid_instr, 32'h00000013);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCAFEF00D;
    tick();
    check("midrst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    check("midrst_ifid_instr2", ifid_instr, 32'h00000013);
    reset = 1'b1;
    #1;
    check("restart_idle_rsp_ready", {31'd0, imem_rsp_ready}, 32'd0);
    check("restart_idle_req_valid", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b0;
    tick();
    check("restart_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("restart_req_addr", imem_req_addr, 32'h00000104);
    check("restart_ifid_valid", {31'd0, ifid_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
